sensor_modn: RTL and testbench



---
 rtl/sensor_mod_pkg.sv | 14 +
 rtl/sensor_mod_step.sv | 24 ++
 rtl/sensor_modn.sv | 90 +++++++++
 tb/tb_sensor_modn.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_mod_pkg.sv
// Shared types and width helpers for the bit-serial sensor modulo reducer.
package sensor_mod_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } modn_state_t;

   function automatic int unsigned cnt_width(input int unsigned data_w);
      return $clog2(data_w + 1);
   endfunction

endpackage

// File: rtl/sensor_mod_step.sv
// One MSB-first shift-and-conditional-subtract step: r' = {r,b} mod m, given r < m.
module sensor_mod_step #(
   parameter int unsigned MOD_W = 4
) (
   input  logic [MOD_W-1:0] r,
   input  logic             b,
   input  logic [MOD_W-1:0] m,
   output logic [MOD_W-1:0] r_next
);

   logic [MOD_W:0] t;
   logic [MOD_W:0] diff;

   always_comb begin
      t    = {r, b};
      diff = t - {1'b0, m};
      if (t >= {1'b0, m}) begin
         r_next = diff[MOD_W-1:0];
      end else begin
         r_next = t[MOD_W-1:0];
      end
   end

endmodule

// File: rtl/sensor_modn.sv
// Bit-serial modulo reducer: out_data = in_data mod in_mod, one data bit per clock,
// valid/ready on both sides, out_err flags a zero modulus.
module sensor_modn
   import sensor_mod_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned MOD_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [MOD_W-1:0]  in_mod,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [MOD_W-1:0]  out_data,
   output logic              out_err
);

   localparam int unsigned CNT_W = cnt_width(DATA_W);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

   modn_state_t       state;
   logic [DATA_W-1:0] sh;
   logic [MOD_W-1:0]  m;
   logic [MOD_W-1:0]  r;
   logic [MOD_W-1:0]  r_step;
   logic [CNT_W-1:0]  cnt;
   logic              err;

   sensor_mod_step #(
      .MOD_W(MOD_W)
   ) u_step (
      .r      (r),
      .b      (sh[DATA_W-1]),
      .m      (m),
      .r_next (r_step)
   );

   // A zero modulus still spends one cycle in RUN (no steps taken, r stays 0),
   // so the error result appears one edge after the accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sh    <= '0;
         m     <= '0;
         r     <= '0;
         cnt   <= '0;
         err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sh    <= in_data;
                  m     <= in_mod;
                  r     <= '0;
                  cnt   <= '0;
                  err   <= (in_mod == '0);
                  state <= RUN;
               end
            end
            RUN: begin
               if (err) begin
                  state <= DONE;
               end else begin
                  r   <= r_step;
                  sh  <= {sh[DATA_W-2:0], 1'b0};
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST_STEP) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign out_data  = r;
   assign out_err   = err;

endmodule

// File: tb/tb_sensor_modn.sv
// Directed self-checking bench for sensor_modn (default 8/4 widths and a 4/3 instance).
module tb_sensor_modn;

   logic clk = 1'b0;
   logic rst_n;

   logic       in_valid, in_ready, out_valid, out_ready, out_err;
   logic [7:0] in_data;
   logic [3:0] in_mod, out_data;

   logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_err;
   logic [3:0] s_in_data;
   logic [2:0] s_in_mod, s_out_data;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sensor_modn #(
      .DATA_W(8),
      .MOD_W (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mod    (in_mod),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err)
   );

   sensor_modn #(
      .DATA_W(4),
      .MOD_W (3)
   ) dut_s (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .in_data   (s_in_data),
      .in_mod    (s_in_mod),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .out_data  (s_out_data),
      .out_err   (s_out_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One request on the 8/4 instance with full latency and handshake checks.
   task automatic run_req(input logic [7:0] d, input logic [3:0] md,
                          input logic [3:0] exp_d, input logic exp_e, input string tag);
      int lat;
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = d;
      in_mod    = md;
      out_ready = 1'b0;
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 8'(~d);
      in_mod   = 4'(~md);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), (md == 4'd0) ? 32'd1 : 32'd8);
      check({tag, "_data"}, 32'(out_data), 32'(exp_d));
      check({tag, "_err"}, 32'(out_err), 32'(exp_e));
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
      check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] smp [5];
      logic [2:0] sexp [5];
      logic [3:0] held;
      logic [11:0] q[$];
      logic [11:0] e;
      logic [3:0] rd, rm;
      logic [7:0] rdd;
      int lat, sent, got;

      smp  = '{4'd6, 4'd13, 4'd10, 4'd3, 4'd9};
      sexp = '{3'd1, 3'd3, 3'd0, 3'd3, 3'd4};

      rst_n = 1'b0;
      in_valid = 1'b0; in_data = '0; in_mod = '0; out_ready = 1'b0;
      s_in_valid = 1'b0; s_in_data = '0; s_in_mod = '0; s_out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_err", 32'(out_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // mod-5 sequence on the 4/3 instance
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         s_in_valid = 1'b1; s_in_data = smp[i]; s_in_mod = 3'd5; s_out_ready = 1'b0;
         @(posedge clk);
         #1;
         s_in_valid = 1'b0; s_in_data = 4'd15; s_in_mod = 3'd2;
         lat = 0;
         while (!s_out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
         end
         check($sformatf("mod5_lat_%0d", i), 32'(lat), 32'd4);
         check($sformatf("mod5_data_%0d", i), 32'(s_out_data), 32'(sexp[i]));
         check($sformatf("mod5_err_%0d", i), 32'(s_out_err), 32'd0);
         @(negedge clk);
         s_out_ready = 1'b1;
         @(posedge clk);
         #1;
         s_out_ready = 1'b0;
      end

      run_req(8'd255, 4'd7, 4'd3, 1'b0, "255m7");
      run_req(8'd200, 4'd15, 4'd5, 1'b0, "200m15");
      run_req(8'd4, 4'd9, 4'd4, 1'b0, "4m9");
      run_req(8'd173, 4'd1, 4'd0, 1'b0, "173m1");
      run_req(8'd77, 4'd0, 4'd0, 1'b1, "77m0");
      run_req(8'd100, 4'd11, 4'd1, 1'b0, "after_err");

      // backpressure: 100 mod 11 = 1 held while inputs churn
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'd100; in_mod = 4'd11; out_ready = 1'b0;
      @(posedge clk);
      #1;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("bp_latency", 32'(lat), 32'd8);
      held = out_data;
      check("bp_data", 32'(held), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1; in_data = 8'(37 * i + 3); in_mod = 4'(i + 2);
         check($sformatf("bp_stable_%0d", i), 32'(out_data), 32'd1);
         check($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'd0);
         check($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'd1);
      end
      @(negedge clk);
      in_data = 8'd50; in_mod = 4'd6; out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("bp_xfer_valid", 32'(out_valid), 32'd0);
      check("bp_xfer_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_next_accept", 32'(in_ready), 32'd0);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("bp_next_lat", 32'(lat), 32'd8);
      check("bp_next_data", 32'(out_data), 32'd2);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;

      // asynchronous reset three steps into RUN (r is 6 at that point)
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'd200; in_mod = 4'd15;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("pre_rst_ready", 32'(in_ready), 32'd0);
      check("pre_rst_data", 32'(out_data), 32'd6);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_ready", 32'(in_ready), 32'd1);
      check("arst_data", 32'(out_data), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_req(8'd200, 4'd15, 4'd5, 1'b0, "rst_rerun");

      // random back-to-back sweep against a % reference
      sent = 0;
      got  = 0;
      for (int cyc = 0; cyc < 60000 && got < 1000; cyc++) begin
         @(negedge clk);
         rdd = 8'($urandom);
         rm  = 4'($urandom_range(0, 15));
         in_valid  = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
         in_data   = rdd;
         in_mod    = rm;
         out_ready = 1'($urandom_range(0, 1));
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("sweep_spurious", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               check("sweep_data", 32'(out_data), 32'(e[3:0]));
               check("sweep_err", 32'(out_err), 32'(e[4]));
               if (!out_err) check("sweep_lt_mod", 32'(out_data < e[8:5]), 32'd1);
            end
            got++;
         end
         if (in_valid && in_ready) begin
            rd = (rm == 4'd0) ? 4'd0 : 4'(rdd % rm);
            q.push_back({3'b0, rm, (rm == 4'd0), rd});
            sent++;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b0;
      check("sweep_received", 32'(got), 32'd1000);
      check("sweep_sent", 32'(sent), 32'd1000);
      check("sweep_leftover", 32'(q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
